// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the core's instruction and data ports.
// Define MEM_BUS_ARB_IBUF_EN to add a one-entry instruction buffer.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_cs,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  rom_stall,
  input  logic                  ram_cs,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  ram_stall,
  output logic                  bus_cs,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] starve;
  logic [DATA_WIDTH-1:0] inst_hold, data_hold;
  logic ireq, dreq, hit, ireq_bus, grant_d, grant_i, inst_ack, data_ack;
`ifdef MEM_BUS_ARB_IBUF_EN
  logic ib_valid;
  logic [ADDR_WIDTH-1:0] ib_addr;
  logic [DATA_WIDTH-1:0] ib_data;
  assign hit = ireq & ib_valid & (inst_addr == ib_addr) & (state != INST);
  assign inst_data = hit ? ib_data : inst_ack ? bus_rdata : inst_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      ib_valid <= 1'b0;
      ib_addr <= '0;
      ib_data <= '0;
    end else if (inst_ack) begin
      ib_valid <= 1'b1;
      ib_addr <= bus_addr;
      ib_data <= bus_rdata;
    end else if (grant_d && mem_wen && mem_addr[ADDR_WIDTH-1:2] == ib_addr[ADDR_WIDTH-1:2]) begin
      ib_valid <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
  assign inst_data = inst_ack ? bus_rdata : inst_hold;
`endif
  always_comb begin
    ireq = rom_cs;
    dreq = ram_cs & (mem_ren | mem_wen);
    ireq_bus = ireq & !hit;
    grant_d = (state == IDLE) & dreq & !(ireq_bus & (starve == SMAX));
    grant_i = (state == IDLE) & !grant_d & ireq_bus;
    inst_ack = (state == INST) & bus_ack;
    data_ack = (state == DATA) & bus_ack;
    state_nxt = grant_d ? DATA : grant_i ? INST : (inst_ack | data_ack) ? IDLE : state;
    rom_stall = ireq_bus & !inst_ack;
    ram_stall = dreq & !data_ack;
    mem_din = (data_ack & !bus_we) ? bus_rdata : data_hold;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus_cs <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      inst_hold <= '0;
      data_hold <= '0;
      starve <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        bus_cs <= 1'b1;
        bus_we <= mem_wen;
        bus_addr <= mem_addr;
        bus_wdata <= mem_dout;
        if (ireq_bus && starve != SMAX) starve <= starve + 1'b1;
      end else if (grant_i) begin
        bus_cs <= 1'b1;
        bus_we <= 1'b0;
        bus_addr <= inst_addr;
        starve <= '0;
      end else if (inst_ack || data_ack) begin
        bus_cs <= 1'b0;
        bus_we <= 1'b0;
      end
      if (inst_ack) inst_hold <= bus_rdata;
      if (data_ack && !bus_we) data_hold <= bus_rdata;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant order, stalls, read-data return and reset behaviour.
module tb_mem_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic rom_cs = 0, ram_cs = 0, mem_ren = 0, mem_wen = 0, bus_ack = 0;
  logic [31:0] inst_addr = 0, mem_addr = 0, mem_dout = 0, bus_rdata = 0;
  logic [31:0] inst_data, mem_din, bus_addr, bus_wdata;
  logic rom_stall, ram_stall, bus_cs, bus_we;
  int checks = 0, errors = 0;
  logic [31:0] exp_addr [6] = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h108, 32'h80};
  always #5 clk = ~clk;
  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .inst_addr(inst_addr), .inst_data(inst_data),
    .rom_stall(rom_stall), .ram_cs(ram_cs), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din), .ram_stall(ram_stall),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_bus_cs", 32'(bus_cs), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_mem_din", mem_din, 0);
    rst = 0;
    // T1: single fetch, ack two cycles after bus_cs
    rom_cs = 1; inst_addr = 32'h100;
    #1 chk("t1_stall_req", 32'(rom_stall), 1);
    tick();
    chk("t1_bus_cs", 32'(bus_cs), 1);
    chk("t1_bus_addr", bus_addr, 32'h100);
    chk("t1_bus_we", 32'(bus_we), 0);
    tick();
    chk("t1_stall_wait", 32'(rom_stall), 1);
    tick();
    bus_ack = 1; bus_rdata = 32'h2408000A;
    #1 chk("t1_stall_ack", 32'(rom_stall), 0);
    chk("t1_inst_data_ack", inst_data, 32'h2408000A);
    tick();
    bus_ack = 0; rom_cs = 0;
    #1 chk("t1_bus_cs_off", 32'(bus_cs), 0);
    chk("t1_inst_data_hold", inst_data, 32'h2408000A);
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_ack = 0;
    chk("idle_ack_bus_cs", 32'(bus_cs), 0);
    chk("idle_ack_inst_data", inst_data, 32'h2408000A);
    // T2: simultaneous requests, data wins
    rom_cs = 1; inst_addr = 32'h104;
    ram_cs = 1; mem_wen = 1; mem_addr = 32'h40; mem_dout = 32'hDEADBEEF;
    #1 chk("t2_ram_stall", 32'(ram_stall), 1);
    tick();
    chk("t2_bus_we", 32'(bus_we), 1);
    chk("t2_bus_addr", bus_addr, 32'h40);
    chk("t2_bus_wdata", bus_wdata, 32'hDEADBEEF);
    bus_ack = 1;
    #1 chk("t2_ram_stall_ack", 32'(ram_stall), 0);
    chk("t2_rom_stall", 32'(rom_stall), 1);
    chk("t2_mem_din_write", mem_din, 0);
    tick();
    bus_ack = 0; ram_cs = 0; mem_wen = 0;
    chk("t2_bubble", 32'(bus_cs), 0);
    tick();
    chk("t2_inst_cs", 32'(bus_cs), 1);
    chk("t2_inst_addr", bus_addr, 32'h104);
    chk("t2_inst_we", 32'(bus_we), 0);
    bus_ack = 1; bus_rdata = 32'h11112222;
    #1 chk("t2_inst_data", inst_data, 32'h11112222);
    tick();
    bus_ack = 0; rom_cs = 0;
    // T3: starvation limit
    rom_cs = 1; inst_addr = 32'h108; ram_cs = 1; mem_ren = 1; mem_addr = 32'h80;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3_cs_%0d", i), 32'(bus_cs), 1);
      chk($sformatf("t3_addr_%0d", i), bus_addr, exp_addr[i]);
      bus_ack = 1; bus_rdata = 32'(i + 1);
      #1;
      if (i == 4) chk("t3_inst_data", inst_data, 32'(i + 1));
      else chk($sformatf("t3_mem_din_%0d", i), mem_din, 32'(i + 1));
      tick();
      bus_ack = 0;
      chk($sformatf("t3_bubble_%0d", i), 32'(bus_cs), 0);
    end
    rom_cs = 0; ram_cs = 0; mem_ren = 0;
    // T4: reset mid-access, late ack ignored
    tick();
    rom_cs = 1; inst_addr = 32'h10C;
    tick();
    chk("t4_grant", 32'(bus_cs), 1);
    tick();
    rst = 1;
    tick();
    chk("t4_cs_dropped", 32'(bus_cs), 0);
    chk("t4_inst_data_rst", inst_data, 0);
    chk("t4_mem_din_rst", mem_din, 0);
    rst = 0; rom_cs = 0;
    #1 chk("t4_stall_norq", 32'(rom_stall), 0);
    tick();
    bus_ack = 1; bus_rdata = 32'hBADBAD00;
    #1 chk("t4_late_ack_data", inst_data, 0);
    tick();
    bus_ack = 0;
    chk("t4_late_ack_cs", 32'(bus_cs), 0);
    chk("t4_late_ack_hold", inst_data, 0);
    // T5: data read then write
    ram_cs = 1; mem_ren = 1; mem_addr = 32'h80;
    tick();
    chk("t5_rd_we", 32'(bus_we), 0);
    chk("t5_rd_addr", bus_addr, 32'h80);
    bus_ack = 1; bus_rdata = 32'h12345678;
    #1 chk("t5_mem_din_ack", mem_din, 32'h12345678);
    tick();
    bus_ack = 0; mem_ren = 0; mem_wen = 1; mem_addr = 32'h84; mem_dout = 32'hCAFEF00D;
    #1 chk("t5_mem_din_hold", mem_din, 32'h12345678);
    tick();
    chk("t5_wr_we", 32'(bus_we), 1);
    chk("t5_wr_wdata", bus_wdata, 32'hCAFEF00D);
    bus_ack = 1; bus_rdata = 32'h55555555;
    #1 chk("t5_wr_mem_din_ack", mem_din, 32'h12345678);
    tick();
    bus_ack = 0; ram_cs = 0; mem_wen = 0;
    #1 chk("t5_wr_mem_din_after", mem_din, 32'h12345678);
    // T6: refetch of the same address
    rom_cs = 1; inst_addr = 32'h200;
    tick();
    chk("t6_fetch1_cs", 32'(bus_cs), 1);
    bus_ack = 1; bus_rdata = 32'h8C010000;
    tick();
    bus_ack = 0; rom_cs = 0;
    tick();
    rom_cs = 1;
`ifdef MEM_BUS_ARB_IBUF_EN
    #1 chk("t6_hit_stall", 32'(rom_stall), 0);
    chk("t6_hit_data", inst_data, 32'h8C010000);
    tick();
    chk("t6_hit_no_cs", 32'(bus_cs), 0);
    rom_cs = 0; ram_cs = 1; mem_wen = 1; mem_addr = 32'h200; mem_dout = 32'h0;
    tick();
    chk("t6_wr_cs", 32'(bus_cs), 1);
    bus_ack = 1;
    tick();
    bus_ack = 0; ram_cs = 0; mem_wen = 0; rom_cs = 1;
    #1 chk("t6_miss_stall", 32'(rom_stall), 1);
    tick();
    chk("t6_refetch_cs", 32'(bus_cs), 1);
    chk("t6_refetch_addr", bus_addr, 32'h200);
`else
    #1 chk("t6_nobuf_stall", 32'(rom_stall), 1);
    tick();
    chk("t6_nobuf_cs", 32'(bus_cs), 1);
    chk("t6_nobuf_addr", bus_addr, 32'h200);
`endif
    bus_ack = 1; bus_rdata = 32'h8C020000;
    tick();
    bus_ack = 0; rom_cs = 0;
    chk("t6_final_data", inst_data, 32'h8C020000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
